frame_sync_ctrl: RTL and testbench
==================================

FRAME_SYNC_CTRL -- requirements
Module: frame_sync_ctrl

Interface
REQ-001 The block SHALL have a parameter H_ACTIVE, default 1280, meaning the visible pixels per line.
REQ-002 The block SHALL have a parameter V_ACTIVE, default 800, meaning the visible lines per frame; curr_y >= V_ACTIVE is vertical blank.
REQ-003 The block SHALL have a parameter BLINK_FRAMES, default 16, meaning the frames per game-over blink half-period (power of two).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (pixel clock, rising edge), rst_n input 1 (asynchronous reset, active low).
REQ-005 Port curr_x SHALL be an input, 11 bits: current pixel column from the VGA timing generator.
REQ-006 Port curr_y SHALL be an input, 10 bits: current pixel row.
REQ-007 Game-side ports SHALL be: game_field input field_t; game_score input 32; game_next input tetromino_ctrl; game_over input 1.
REQ-008 Handshake ports SHALL be: upd_req input 1 (game snapshot valid and stable); upd_ack output 1 (snapshot taken).
REQ-009 Renderer-side ports SHALL be: display output field_t; score output 32; t_next output tetromino_ctrl; game_over_disp output 1; blink_on output 1.
REQ-010 Status ports SHALL be: frame_cnt output 16 (count of vblank entries); stale_cnt output 8 (count of frames ended without update).

Function
REQ-011 vblank_start SHALL be the single-cycle condition curr_y == V_ACTIVE and curr_x == 0.
REQ-012 The FSM states SHALL be S_ACTIVE, S_VBLANK and S_ACK.
REQ-013 In S_ACTIVE, on vblank_start the FSM SHALL go to S_VBLANK and frame_cnt SHALL increment, wrapping at 16 bits.
REQ-014 In S_VBLANK with upd_req=1 and curr_y >= V_ACTIVE, all renderer outputs SHALL load from the game inputs on that edge, and the FSM SHALL go to S_ACK.
REQ-015 In S_VBLANK with curr_y < V_ACTIVE, whether or not upd_req is high, the FSM SHALL return to S_ACTIVE without capture, and stale_cnt SHALL increment, saturating at 255.
REQ-016 upd_ack SHALL be 1 exactly while in S_ACK, i.e. from the cycle after capture; in S_ACK with upd_req=0 the FSM SHALL return to S_ACTIVE.
REQ-017 At most one capture SHALL occur per frame; a vblank_start seen while in S_ACK is counted in frame_cnt but SHALL NOT open a second capture window.
REQ-018 upd_req asserted during active video SHALL be held pending, with no ack, until the next S_VBLANK.
REQ-019 Renderer outputs SHALL change only on a capture edge, and so never change during active video.
REQ-020 A blink counter (log2(BLINK_FRAMES) bits) SHALL advance on each vblank_start while game_over_disp=1, and blink_on SHALL toggle when the counter wraps to 0.
REQ-021 While game_over_disp=0, the blink counter and blink_on SHALL be held at 0; a capture that sets game_over_disp starts the count at 0.
REQ-022 Latency: a capture edge SHALL make the outputs visible one cycle later, with upd_ack=1 in the same cycle.

Reset
REQ-023 rst_n=0 SHALL asynchronously force: state S_ACTIVE; upd_ack 0; every display cell TETROMINO_EMPTY; score 0; t_next all zero; game_over_disp 0; blink_on 0; blink counter 0; frame_cnt 0; stale_cnt 0.
REQ-024 A reset in mid-handshake SHALL drop upd_ack immediately; after release, a still-high upd_req SHALL be served in the next vblank.

Structure
REQ-025 field_t, tetromino_ctrl, TETROMINO_EMPTY and FIELD_* SHALL remain in the shared GLOBAL package, and the H_ACTIVE/V_ACTIVE timing constants SHALL be added to it.
REQ-026 The block SHALL be a single module with no sub-module; the FSM, counters and capture registers SHALL live in one file.

Verification
REQ-027 Scenario: reset, then run 3 frames with no upd_req -> frame_cnt=3, stale_cnt=3, display all empty, score=0.
REQ-028 Scenario: upd_req raised at curr_y=100 with score=1234 -> score stays 0 until the vblank_start edge, loads 1234 on the cycle after S_VBLANK entry, upd_ack rises with it, and upd_ack falls one cycle after upd_req drops.
REQ-029 Scenario: upd_req held high for 3 frames -> exactly one capture, and frame_cnt advances by 3.
REQ-030 Scenario: game_over=1 captured, then 32 frames -> blink_on toggles at frames 16 and 32; game_over=0 captured -> blink_on=0 on the next cycle.
REQ-031 Scenario: rst_n pulsed low while upd_ack=1 -> upd_ack=0 and score=0 with no clock edge; upd_req kept high -> re-acked in the following vblank.
REQ-032 Scenario: 300 frames without update -> stale_cnt saturates at 255.

Source files
------------

// File: rtl/global_pkg.sv
// Shared game types and display timing constants used by the game core,
// the frame synchroniser and the renderer.
package global_pkg;

    localparam int H_ACTIVE = 1280;
    localparam int V_ACTIVE = 800;

    localparam int FIELD_W = 10;
    localparam int FIELD_H = 20;

    typedef enum logic [2:0] {
        TETROMINO_EMPTY = 3'd0,
        TETROMINO_I     = 3'd1,
        TETROMINO_O     = 3'd2,
        TETROMINO_T     = 3'd3,
        TETROMINO_S     = 3'd4,
        TETROMINO_Z     = 3'd5,
        TETROMINO_J     = 3'd6,
        TETROMINO_L     = 3'd7
    } tetromino_t;

    typedef tetromino_t [FIELD_H-1:0][FIELD_W-1:0] field_t;

    typedef struct packed {
        tetromino_t  kind;
        logic [1:0]  rot;
        logic [3:0]  col;
        logic [4:0]  row;
    } tetromino_ctrl;

    function automatic field_t empty_field();
        field_t f;
        for (int r = 0; r < FIELD_H; r++) begin
            for (int c = 0; c < FIELD_W; c++) begin
                f[r][c] = TETROMINO_EMPTY;
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/frame_sync_ctrl.sv
// Takes one game-state snapshot per vertical blank under an upd_req/upd_ack
// handshake, so the renderer never sees the field change mid-frame.
module frame_sync_ctrl #(
    parameter int H_ACTIVE     = global_pkg::H_ACTIVE,
    parameter int V_ACTIVE     = global_pkg::V_ACTIVE,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [10:0]               curr_x,
    input  logic [9:0]                curr_y,
    input  global_pkg::field_t        game_field,
    input  logic [31:0]               game_score,
    input  global_pkg::tetromino_ctrl game_next,
    input  logic                      game_over,
    input  logic                      upd_req,
    output logic                      upd_ack,
    output global_pkg::field_t        display,
    output logic [31:0]               score,
    output global_pkg::tetromino_ctrl t_next,
    output logic                      game_over_disp,
    output logic                      blink_on,
    output logic [15:0]               frame_cnt,
    output logic [7:0]                stale_cnt
);

    localparam int         BW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [9:0] V_LINE = 10'(V_ACTIVE);

    if (H_ACTIVE < 1 || H_ACTIVE > 2047 || V_ACTIVE < 1 || V_ACTIVE > 1023 ||
        BLINK_FRAMES < 2 || (BLINK_FRAMES & (BLINK_FRAMES - 1)) != 0) begin : g_bad_params
        $error("frame_sync_ctrl: timing or blink parameters out of range");
    end

    typedef enum logic [1:0] {S_ACTIVE, S_VBLANK, S_ACK} state_t;

    state_t                    state_q,     state_d;
    logic                      upd_ack_q,   upd_ack_d;
    global_pkg::field_t        display_q,   display_d;
    logic [31:0]               score_q,     score_d;
    global_pkg::tetromino_ctrl t_next_q,    t_next_d;
    logic                      go_disp_q,   go_disp_d;
    logic                      blink_on_q,  blink_on_d;
    logic [BW-1:0]             blink_cnt_q, blink_cnt_d;
    logic [15:0]               frame_cnt_q, frame_cnt_d;
    logic [7:0]                stale_cnt_q, stale_cnt_d;
    logic                      vblank_start;
    logic                      capture;

    always_comb begin
        vblank_start = (curr_y == V_LINE) && (curr_x == 11'd0);
        state_d      = state_q;
        capture      = 1'b0;
        stale_cnt_d  = stale_cnt_q;

        case (state_q)
            S_ACTIVE: begin
                if (vblank_start) state_d = S_VBLANK;
            end
            S_VBLANK: begin
                // Blank ended with no snapshot taken: the renderer shows a stale frame.
                if (curr_y < V_LINE) begin
                    state_d = S_ACTIVE;
                    if (stale_cnt_q != 8'hFF) stale_cnt_d = stale_cnt_q + 8'd1;
                end else if (upd_req) begin
                    state_d = S_ACK;
                    capture = 1'b1;
                end
            end
            S_ACK: begin
                if (!upd_req) state_d = S_ACTIVE;
            end
            default: state_d = S_ACTIVE;
        endcase

        upd_ack_d   = (state_d == S_ACK);
        frame_cnt_d = frame_cnt_q + 16'(vblank_start);

        display_d = capture ? game_field : display_q;
        score_d   = capture ? game_score : score_q;
        t_next_d  = capture ? game_next  : t_next_q;
        go_disp_d = capture ? game_over  : go_disp_q;

        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (!go_disp_q) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b0;
        end else if (vblank_start) begin
            blink_cnt_d = blink_cnt_q + BW'(1);
            if (blink_cnt_d == '0) blink_on_d = ~blink_on_q;
        end
        // Leaving game-over must blank the overlay on the very next cycle.
        if (capture && !game_over) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_ACTIVE;
            upd_ack_q   <= 1'b0;
            display_q   <= global_pkg::empty_field();
            score_q     <= '0;
            t_next_q    <= '0;
            go_disp_q   <= 1'b0;
            blink_on_q  <= 1'b0;
            blink_cnt_q <= '0;
            frame_cnt_q <= '0;
            stale_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            upd_ack_q   <= upd_ack_d;
            display_q   <= display_d;
            score_q     <= score_d;
            t_next_q    <= t_next_d;
            go_disp_q   <= go_disp_d;
            blink_on_q  <= blink_on_d;
            blink_cnt_q <= blink_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            stale_cnt_q <= stale_cnt_d;
        end
    end

    assign upd_ack        = upd_ack_q;
    assign display        = display_q;
    assign score          = score_q;
    assign t_next         = t_next_q;
    assign game_over_disp = go_disp_q;
    assign blink_on       = blink_on_q;
    assign frame_cnt      = frame_cnt_q;
    assign stale_cnt      = stale_cnt_q;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Bench for frame_sync_ctrl: small raster, directed scenarios plus random
// handshake traffic checked every cycle against a frame-level reference model.
module tb_frame_sync_ctrl;
    import global_pkg::*;

    localparam int HA     = 8;
    localparam int VA     = 6;
    localparam int HT     = 10;
    localparam int VT     = 8;
    localparam int BF     = 16;
    localparam int FRAME  = HT * VT;
    localparam int NEXT_W = $bits(tetromino_ctrl);

    logic          clk;
    logic          rst_n;
    logic [10:0]   curr_x;
    logic [9:0]    curr_y;
    field_t        game_field;
    logic [31:0]   game_score;
    tetromino_ctrl game_next;
    logic          game_over;
    logic          upd_req;
    logic          upd_ack;
    field_t        display;
    logic [31:0]   score;
    tetromino_ctrl t_next;
    logic          game_over_disp;
    logic          blink_on;
    logic [15:0]   frame_cnt;
    logic [7:0]    stale_cnt;

    frame_sync_ctrl #(
        .H_ACTIVE    (HA),
        .V_ACTIVE    (VA),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .curr_x        (curr_x),
        .curr_y        (curr_y),
        .game_field    (game_field),
        .game_score    (game_score),
        .game_next     (game_next),
        .game_over     (game_over),
        .upd_req       (upd_req),
        .upd_ack       (upd_ack),
        .display       (display),
        .score         (score),
        .t_next        (t_next),
        .game_over_disp(game_over_disp),
        .blink_on      (blink_on),
        .frame_cnt     (frame_cnt),
        .stale_cnt     (stale_cnt)
    );

    always begin
        clk = 1'b0;
        #5;
        clk = 1'b1;
        #5;
    end

    int n_checks;
    int n_fail;

    // Reference model: per-frame rules, not the DUT's state encoding.
    bit            m_window;
    bit            m_acked;
    field_t        m_field;
    logic [31:0]   m_score;
    tetromino_ctrl m_next;
    bit            m_go;
    int            m_go_frames;
    logic [15:0]   m_frames;
    int            m_stale;
    field_t        empty_f;

    task automatic check_val(input string tag, input logic [639:0] act, input logic [639:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    function automatic field_t rand_field();
        field_t f;
        for (int r = 0; r < FIELD_H; r++) begin
            for (int c = 0; c < FIELD_W; c++) begin
                f[r][c] = tetromino_t'(3'($urandom_range(0, 7)));
            end
        end
        return f;
    endfunction

    task automatic model_reset();
        m_window    = 1'b0;
        m_acked     = 1'b0;
        m_field     = empty_f;
        m_score     = '0;
        m_next      = '0;
        m_go        = 1'b0;
        m_go_frames = 0;
        m_frames    = '0;
        m_stale     = 0;
    endtask

    task automatic model_step();
        bit vs;
        bit cap;
        vs  = (int'(curr_y) == VA) && (curr_x == 11'd0);
        cap = 1'b0;
        if (m_acked) begin
            if (!upd_req) m_acked = 1'b0;
        end else if (m_window) begin
            if (int'(curr_y) < VA) begin
                m_window = 1'b0;
                if (m_stale < 255) m_stale++;
            end else if (upd_req) begin
                cap      = 1'b1;
                m_window = 1'b0;
                m_acked  = 1'b1;
            end
        end else if (vs) begin
            m_window = 1'b1;
        end
        if (vs) m_frames = m_frames + 16'd1;
        if (vs && m_go) m_go_frames++;
        if (cap) begin
            m_field = game_field;
            m_score = game_score;
            m_next  = game_next;
            m_go    = game_over;
            if (!game_over) m_go_frames = 0;
        end
    endtask

    task automatic compare_all();
        bit exp_blink;
        exp_blink = m_go && (((m_go_frames / BF) % 2) == 1);
        check_val("upd_ack",        640'(upd_ack),        640'(m_acked));
        check_val("score",          640'(score),          640'(m_score));
        check_val("display",        640'(display),        640'(m_field));
        check_val("t_next",         640'(t_next),         640'(m_next));
        check_val("game_over_disp", 640'(game_over_disp), 640'(m_go));
        check_val("blink_on",       640'(blink_on),       640'(exp_blink));
        check_val("frame_cnt",      640'(frame_cnt),      640'(m_frames));
        check_val("stale_cnt",      640'(stale_cnt),      640'(m_stale));
    endtask

    task automatic advance_timing();
        if (curr_x == 11'(HT - 1)) begin
            curr_x = 11'd0;
            curr_y = (curr_y == 10'(VT - 1)) ? 10'd0 : curr_y + 10'd1;
        end else begin
            curr_x = curr_x + 11'd1;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        advance_timing();
    endtask

    task automatic run_to(input int y, input int x);
        int n;
        n = 0;
        while (!(int'(curr_y) == y && int'(curr_x) == x) && n < FRAME) begin
            cycle();
            n++;
        end
    endtask

    task automatic wait_ack(input string tag, input int budget);
        int n;
        n = 0;
        while (upd_ack !== 1'b1 && n < budget) begin
            cycle();
            n++;
        end
        check_val(tag, 640'(upd_ack), 640'(1'b1));
    endtask

    initial begin
        int rises;
        logic prev_ack;
        logic [15:0] f0;

        n_checks = 0;
        n_fail   = 0;
        for (int r = 0; r < FIELD_H; r++) begin
            for (int c = 0; c < FIELD_W; c++) begin
                empty_f[r][c] = TETROMINO_EMPTY;
            end
        end
        rst_n      = 1'b0;
        curr_x     = 11'd0;
        curr_y     = 10'd0;
        game_field = rand_field();
        game_score = 32'd55;
        game_next  = tetromino_ctrl'(NEXT_W'($urandom));
        game_over  = 1'b0;
        upd_req    = 1'b0;
        model_reset();

        #12;
        check_val("rst_upd_ack",   640'(upd_ack),        640'(0));
        check_val("rst_score",     640'(score),          640'(0));
        check_val("rst_display",   640'(display),        640'(empty_f));
        check_val("rst_t_next",    640'(t_next),         640'(0));
        check_val("rst_go_disp",   640'(game_over_disp), 640'(0));
        check_val("rst_blink",     640'(blink_on),       640'(0));
        check_val("rst_frame_cnt", 640'(frame_cnt),      640'(0));
        check_val("rst_stale_cnt", 640'(stale_cnt),      640'(0));
        rst_n = 1'b1;

        // Three idle frames.
        repeat (3 * FRAME + 1) cycle();
        check_val("idle_frame_cnt", 640'(frame_cnt), 640'(3));
        check_val("idle_stale_cnt", 640'(stale_cnt), 640'(3));
        check_val("idle_display",   640'(display),   640'(empty_f));
        check_val("idle_score",     640'(score),     640'(0));

        // Request raised mid-frame is held until blank.
        run_to(2, 0);
        game_score = 32'd1234;
        game_field = rand_field();
        upd_req    = 1'b1;
        for (int n = 0; n < FRAME && !(int'(curr_y) == VA && curr_x == 11'd0); n++) begin
            cycle();
            check_val("score_before_vs", 640'(score), 640'(0));
        end
        cycle();
        check_val("score_at_vs", 640'(score),   640'(0));
        check_val("ack_at_vs",   640'(upd_ack), 640'(0));
        cycle();
        check_val("score_load",  640'(score),   640'(32'd1234));
        check_val("ack_rise",    640'(upd_ack), 640'(1));
        game_score = 32'd777;
        cycle();
        check_val("ack_hold",    640'(upd_ack), 640'(1));
        check_val("score_kept",  640'(score),   640'(32'd1234));
        upd_req = 1'b0;
        cycle();
        check_val("ack_fall",    640'(upd_ack), 640'(0));

        // Request held for three frames: a single capture.
        run_to(0, 0);
        f0       = frame_cnt;
        upd_req  = 1'b1;
        rises    = 0;
        prev_ack = upd_ack;
        repeat (3 * FRAME) begin
            game_score = $urandom;
            game_next  = tetromino_ctrl'(NEXT_W'($urandom));
            cycle();
            if (upd_ack && !prev_ack) rises++;
            prev_ack = upd_ack;
        end
        check_val("held_req_captures", 640'(rises),     640'(1));
        check_val("held_req_frames",   640'(frame_cnt), 640'(f0 + 16'd3));
        upd_req = 1'b0;
        cycle();

        // Game-over blink.
        game_over = 1'b1;
        upd_req   = 1'b1;
        wait_ack("ack_go1", 2 * FRAME);
        upd_req = 1'b0;
        cycle();
        check_val("go_disp_set",  640'(game_over_disp), 640'(1));
        check_val("blink_start",  640'(blink_on),       640'(0));
        for (int k = 1; k <= 48; k++) begin
            run_to(VA, 0);
            cycle();
            if (k == 15) check_val("blink_f15", 640'(blink_on), 640'(0));
            if (k == 16) check_val("blink_f16", 640'(blink_on), 640'(1));
            if (k == 31) check_val("blink_f31", 640'(blink_on), 640'(1));
            if (k == 32) check_val("blink_f32", 640'(blink_on), 640'(0));
            if (k == 48) check_val("blink_f48", 640'(blink_on), 640'(1));
        end
        game_over = 1'b0;
        upd_req   = 1'b1;
        wait_ack("ack_go0", 2 * FRAME);
        check_val("blink_cleared", 640'(blink_on),       640'(0));
        check_val("go_disp_clr",   640'(game_over_disp), 640'(0));
        upd_req = 1'b0;
        cycle();

        // Reset in the middle of a handshake.
        game_score = $urandom | 32'h1;
        upd_req    = 1'b1;
        wait_ack("ack_pre_rst", 2 * FRAME);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("midrst_ack",     640'(upd_ack), 640'(0));
        check_val("midrst_score",   640'(score),   640'(0));
        check_val("midrst_display", 640'(display), 640'(empty_f));
        model_reset();
        #1;
        rst_n = 1'b1;
        wait_ack("ack_after_rst", 2 * FRAME);
        check_val("score_reack", 640'(score), 640'(game_score));
        upd_req = 1'b0;
        cycle();

        // Random handshake traffic.
        repeat (40 * FRAME) begin
            if ($urandom_range(0, 19) == 0) upd_req = ~upd_req;
            game_score = $urandom;
            game_next  = tetromino_ctrl'(NEXT_W'($urandom));
            if ($urandom_range(0, 49) == 0) game_field = rand_field();
            if ($urandom_range(0, 99) == 0) game_over = ~game_over;
            cycle();
        end

        // Long idle run saturates the stale counter.
        upd_req = 1'b0;
        repeat (300 * FRAME + 1) cycle();
        check_val("stale_saturated", 640'(stale_cnt), 640'(255));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
